render_frame_sequencer: RTL

//  Per-frame controller for the 3D render datapath (a3d_to_2d -> rasterize -> zbuffer -> color BRAM).

---
 rtl/render_frame_sequencer.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/render_frame_sequencer.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// render_frame_sequencer
//
// Per-frame controller for the 3D render datapath
// (a3d_to_2d -> rasterize -> zbuffer -> color BRAM).
// The color BRAM is double-buffered. For each frame the block does three things:
//   1. It clears the back buffer to BG_COLOR.
//   2. It kicks one render pass with a camera location that stays fixed for the frame.
//   3. After the pass finishes, it swaps front/back on the next vsync rising edge,
//      so the VGA reader never sees a partial frame.
// A new frame begins on the same edge that performs the swap.
//
// Optional feature macro: RENDER_TIMEOUT_EN
//   Defined   : RENDER is aborted after TIMEOUT cycles without render_done_in
//               (one-cycle timeout_out pulse). The partial frame is swapped normally.
//   Undefined : RENDER waits indefinitely; timeout_out is tied low.
//
// Ports
//   clk              in   1       system clock (pixel domain)
//   rst_n            in   1       asynchronous active-low reset
//   vsync_in         in   1       active-high VGA vsync level
//   camera_loc_in    in   LOCW    requested camera location
//   camera_valid_in  in   1       camera_loc_in is valid
//   render_done_in   in   1       pulse: last zbuffer write of the pass issued
//   clear_we_out     out  1       back-buffer clear write enable
//   clear_addr_out   out  ADDRW   clear write address
//   clear_data_out   out  COLORW  clear data (BG_COLOR)
//   render_start_out out  1       one-cycle pulse into a3d_to_2d valid_in
//   camera_loc_out   out  LOCW    camera location for the current pass
//   render_en_out    out  1       high in RENDER; gates zbuffer writes
//   back_sel_out     out  1       buffer being written; front = ~back_sel_out
//   frame_done_out   out  1       one-cycle pulse on swap
//   timeout_out      out  1       one-cycle pulse on render abort
//   busy_out         out  1       state != IDLE
// All outputs are registered.
// -----------------------------------------------------------------------------
module render_frame_sequencer #(
  parameter int unsigned       ADDRW    = 12,
  parameter int unsigned       DEPTH    = 4096,
  parameter int unsigned       COLORW   = 10,
  parameter logic [COLORW-1:0] BG_COLOR = '0,
  parameter int unsigned       LOCW     = 30,
  parameter int unsigned       TIMEOUT  = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vsync_in,
  input  logic [LOCW-1:0]   camera_loc_in,
  input  logic              camera_valid_in,
  input  logic              render_done_in,
  output logic              clear_we_out,
  output logic [ADDRW-1:0]  clear_addr_out,
  output logic [COLORW-1:0] clear_data_out,
  output logic              render_start_out,
  output logic [LOCW-1:0]   camera_loc_out,
  output logic              render_en_out,
  output logic              back_sel_out,
  output logic              frame_done_out,
  output logic              timeout_out,
  output logic              busy_out
);

  // Elaboration-time guard against parameter sets that cannot work.
  if (DEPTH < 1 || DEPTH > (2 ** ADDRW) || TIMEOUT < 1) begin : g_bad_params
    $error("render_frame_sequencer: illegal DEPTH/ADDRW/TIMEOUT combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_START,
    S_RENDER,
    S_WAIT_SWAP
  } state_e;

  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(DEPTH - 1);

  // ---------------------------------------------------------------------------
  // Registers and next-state wires
  // ---------------------------------------------------------------------------
  state_e              r_state;
  logic                r_vsync_q;
  logic                r_clear_we;
  logic [ADDRW-1:0]    r_clear_addr;
  logic [COLORW-1:0]   r_clear_data;
  logic                r_render_start;
  logic [LOCW-1:0]     r_camera_loc;
  logic                r_render_en;
  logic                r_back_sel;
  logic                r_frame_done;
  logic                r_busy;

  state_e              w_next_state;
  logic                w_vsync_edge;
  logic                w_frame_start;
  logic                w_clear_we_d;
  logic [ADDRW-1:0]    w_clear_addr_d;
  logic                w_render_start_d;
  logic [LOCW-1:0]     w_camera_loc_d;
  logic                w_render_en_d;
  logic                w_back_sel_d;
  logic                w_frame_done_d;
  logic                w_busy_d;

`ifdef RENDER_TIMEOUT_EN
  // The counter only needs to reach TIMEOUT-1: the expiry decision is made in the
  // TIMEOUT-th RENDER cycle, and the registered pulse appears one cycle later.
  localparam int unsigned     TMRW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMRW-1:0] TMR_LAST = TMRW'(TIMEOUT - 1);

  logic            r_timeout;
  logic [TMRW-1:0] r_timer;
  logic            w_timeout_d;
  logic [TMRW-1:0] w_timer_d;
  logic            w_timer_expired;

  assign w_timer_expired = (r_timer == TMR_LAST);
`endif

  assign w_vsync_edge = vsync_in & ~r_vsync_q;

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal is given a default first, so no path through the case
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_next_state     = r_state;
    w_frame_start    = 1'b0;
    w_clear_we_d     = 1'b0;
    w_clear_addr_d   = r_clear_addr;
    w_render_start_d = 1'b0;
    w_camera_loc_d   = r_camera_loc;
    w_render_en_d    = 1'b0;
    w_back_sel_d     = r_back_sel;
    w_frame_done_d   = 1'b0;
`ifdef RENDER_TIMEOUT_EN
    w_timeout_d      = 1'b0;
    w_timer_d        = r_timer;
`endif

    unique case (r_state)
      S_IDLE: begin
        if (w_vsync_edge) w_frame_start = 1'b1;
      end

      S_CLEAR: begin
        // The current cycle writes r_clear_addr. Stop after the last word,
        // holding the address rather than wrapping.
        if (r_clear_addr == LAST_ADDR) begin
          w_next_state     = S_START;
          w_render_start_d = 1'b1;
        end else begin
          w_clear_we_d   = 1'b1;
          w_clear_addr_d = r_clear_addr + ADDRW'(1);
        end
      end

      S_START: begin
        w_next_state  = S_RENDER;
        w_render_en_d = 1'b1;
`ifdef RENDER_TIMEOUT_EN
        w_timer_d     = '0;
`endif
      end

      S_RENDER: begin
        // A vsync edge here is ignored: the front buffer keeps the previous frame.
        if (render_done_in) begin
          w_next_state = S_WAIT_SWAP;
        end
`ifdef RENDER_TIMEOUT_EN
        else if (w_timer_expired) begin
          w_next_state = S_WAIT_SWAP;
          w_timeout_d  = 1'b1;
        end
`endif
        else begin
          w_render_en_d = 1'b1;
`ifdef RENDER_TIMEOUT_EN
          w_timer_d     = r_timer + TMRW'(1);
`endif
        end
      end

      S_WAIT_SWAP: begin
        if (w_vsync_edge) begin
          w_frame_start  = 1'b1;
          w_back_sel_d   = ~r_back_sel;
          w_frame_done_d = 1'b1;
        end
      end

      default: w_next_state = S_IDLE;
    endcase

    // A frame start (from IDLE or on a swap) latches the camera and begins clearing.
    if (w_frame_start) begin
      w_next_state   = S_CLEAR;
      w_clear_we_d   = 1'b1;
      w_clear_addr_d = '0;
      if (camera_valid_in) w_camera_loc_d = camera_loc_in;
    end

    w_busy_d = (w_next_state != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: reset is asynchronous and clears every register; a reset mid-frame
  // stops clear writes and start pulses immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_vsync_q      <= 1'b0;
      r_clear_we     <= 1'b0;
      r_clear_addr   <= '0;
      r_clear_data   <= '0;
      r_render_start <= 1'b0;
      r_camera_loc   <= '0;
      r_render_en    <= 1'b0;
      r_back_sel     <= 1'b0;
      r_frame_done   <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_vsync_q      <= vsync_in;
      r_clear_we     <= w_clear_we_d;
      r_clear_addr   <= w_clear_addr_d;
      r_clear_data   <= BG_COLOR;
      r_render_start <= w_render_start_d;
      r_camera_loc   <= w_camera_loc_d;
      r_render_en    <= w_render_en_d;
      r_back_sel     <= w_back_sel_d;
      r_frame_done   <= w_frame_done_d;
      r_busy         <= w_busy_d;
    end
  end

`ifdef RENDER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timer   <= w_timer_d;
      r_timeout <= w_timeout_d;
    end
  end

  assign timeout_out = r_timeout;
`else
  assign timeout_out = 1'b0;
`endif

  assign clear_we_out     = r_clear_we;
  assign clear_addr_out   = r_clear_addr;
  assign clear_data_out   = r_clear_data;
  assign render_start_out = r_render_start;
  assign camera_loc_out   = r_camera_loc;
  assign render_en_out    = r_render_en;
  assign back_sel_out     = r_back_sel;
  assign frame_done_out   = r_frame_done;
  assign busy_out         = r_busy;

endmodule
